apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Parametrised APB3 requester that turns a valid/ready command stream into APB transfers on a single slave port. It supports PREADY wait states and PSLVERR, a configurable command buffer, and an access timeout. It sits between a testbench/sequencer-side command source or on-chip controller and the register bus of a DUT such as the MCDF register block. It generalises the fixed 32-bit, zero-wait-state APB master connection to arbitrary widths with buffered, back-pressured operation.

Parameters:
ADDR_W, 32, width of paddr/cmd_addr
DATA_W, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata (multiple of 8)
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 16, max ACCESS cycles awaiting pready; 0 disables timeout

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (= !full)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr sampled or timeout
rsp_timeout  out  1  transfer terminated by timeout
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rstn low, async): all outputs 0 except cmd_ready=1; FIFO emptied; FSM=IDLE; timeout counter=0. All outputs are registered except cmd_ready and busy (decoded from registered state).
- FIFO: push on cmd_valid&&cmd_ready; cmd_ready=!full and has no same-cycle pop bypass, so a full FIFO stays not-ready even while popping. Pointers wrap modulo CMD_DEPTH; a count register distinguishes full from empty. Commands are issued in FIFO order.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if FIFO is non-empty, pop, load paddr/pwrite/pwdata, set psel=1, penable=0, and go to SETUP. An empty FIFO stays IDLE with psel=0.
- SETUP: lasts exactly one cycle. Set penable=1, clear timeout counter, go to ACCESS.
- ACCESS: sample pready each cycle.
  - pready=1: capture rsp_rdata=prdata (reads) or 0 (writes), rsp_err=pslverr, rsp_timeout=0. Drop psel/penable, set rsp_valid=1, go to RESP.
  - pready=0: increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with pready still 0, abort: psel=penable=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1, go to RESP.
  - pready=1 on the final allowed cycle completes normally; completion takes priority over timeout.
- RESP: hold rsp_* stable while rsp_ready=0. On rsp_ready=1, clear rsp_valid. If the FIFO is non-empty, pop and go directly to SETUP (psel=1 next cycle); otherwise go to IDLE.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS, then hold their last value; they change only on a pop.
- pslverr is ignored except in the pready=1 ACCESS cycle. pslverr on a write still reports rsp_err=1 with rsp_rdata=0.
- Latency: a command accepted at cycle N into an empty, IDLE bridge gives psel=1 at N+1, penable=1 at N+2. With pready=1 at N+2, rsp_valid=1 at N+3. Each wait state adds one cycle.
- Only one APB transfer is outstanding at a time; FIFO back-pressure is the only flow control toward cmd.
- Reset mid-transfer: psel/penable drop immediately (async). Pending commands and any undelivered response are discarded.

Test Plan:
- Write addr 0x04, data 0xA5A5_0001, pready=1 -> psel at N+1, penable at N+2; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read 0x10, pready low for 3 ACCESS cycles, prdata=0x1234_5678 -> penable high 4 cycles; rsp_rdata=0x1234_5678; paddr stable throughout.
- Read with pslverr=1 at the pready cycle -> rsp_err=1, rsp_timeout=0, data captured.
- TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then psel=0 and rsp_err=rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 on cycle 16 -> normal completion.
- rsp_ready=0, push 1+CMD_DEPTH commands -> cmd_ready low after 5 accepted (1 in flight + 4 buffered). Release rsp_ready -> back-to-back SETUP, responses in order, no command lost or duplicated.
- rstn asserted during ACCESS with 2 commands queued -> psel=penable=rsp_valid=0 asynchronously, cmd_ready=1, busy=0; first post-reset command behaves as in scenario 1.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Buffered APB3 requester. Commands arrive on a valid/ready stream, are
//   queued in a CMD_DEPTH-entry FIFO and issued one at a time as APB
//   transfers. Each transfer yields one response on a valid/ready stream,
//   carrying read data, slave error, and an optional access timeout.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata  command stream in (cmd_ready = !full)
//   rsp_valid/ready/rdata/err/timeout response stream out
//   paddr/pwrite/psel/penable/pwdata  APB request outputs
//   prdata/pready/pslverr             APB completion inputs
//   busy                              FIFO non-empty or transfer/response pending
module apb_master_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(CMD_DEPTH);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  // Command FIFO
  logic [ENT_W-1:0] mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  // FSM and registered outputs
  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != FIFO_FULL);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rd_ptr_q];
  assign busy       = !fifo_empty || (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        tmo_cnt_d = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // Completion is checked first so pready on the last allowed cycle wins.
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = S_RESP;
        end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The APB request fields change only when a command is taken from the FIFO.
    if (pop) begin
      pwrite_d = head[ENT_W-1];
      paddr_d  = head[ADDR_W+DATA_W-1:DATA_W];
      pwdata_d = head[DATA_W-1:0];
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tmo_cnt_q     <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tmo_cnt_q     <= tmo_cnt_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: commands push an APB slave config
// and an expected response; a slave model and a response monitor check them.
module tb_apb_master_bridge;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata  = '0;
  logic          pready  = 1'b0;
  logic          pslverr = 1'b0;
  logic          busy;

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    int            waits;   // pready-low ACCESS cycles; >= TMO means never ready
    logic [DW-1:0] rdata;
    logic          slverr;
  } cfg_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  cfg_t cfg_q[$];
  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command; expected response is derived from the slave config.
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input logic [DW-1:0] rd, input logic se);
    cfg_t c;
    rsp_t r;
    int   budget;
    logic tmo;
    c.addr = a; c.write = w; c.wdata = wd; c.waits = waits; c.rdata = rd; c.slverr = se;
    tmo     = (waits >= TMO);
    r.rdata = (tmo || w) ? '0 : rd;
    r.err   = tmo || se;
    r.tmo   = tmo;
    cfg_q.push_back(c);
    exp_q.push_back(r);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    budget = 0;
    while (!cmd_ready && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!cmd_ready) begin
      check("push_accept", {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while ((busy || rsp_valid || exp_q.size() != 0) && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 500) check("drain_busy", {63'd0, busy}, 64'd0);
  endtask

  // Single write into an idle bridge; cycle-exact latency checks.
  task automatic latency_write();
    push(1'b1, 32'h0000_0004, 32'hA5A5_0001, 0, '0, 1'b0);
    @(negedge clk);
    check("lat_n0_psel", {63'd0, psel}, 64'd0);
    check("lat_n0_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("lat_n1_psel_pen", {62'd0, psel, penable}, 64'd2);
    check("lat_n1_paddr", {32'd0, paddr}, 64'h4);
    check("lat_n1_pwdata", {32'd0, pwdata}, 64'hA5A5_0001);
    @(negedge clk);
    check("lat_n2_psel_pen", {62'd0, psel, penable}, 64'd3);
    @(negedge clk);
    check("lat_n3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("lat_n3_psel", {63'd0, psel}, 64'd0);
    wait_idle();
  endtask

  // APB slave model: checks request fields and ACCESS length per transfer.
  cfg_t cur;
  int   acc = 0;
  bit   in_xfer = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      in_xfer = 1'b0;
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel && !penable) begin
      pready = 1'b0;
      if (cfg_q.size() == 0) begin
        check("unexpected_setup", {63'd0, psel}, 64'd0);
      end else begin
        cur = cfg_q.pop_front();
        check("setup_paddr", {32'd0, paddr}, {32'd0, cur.addr});
        check("setup_pwrite", {63'd0, pwrite}, {63'd0, cur.write});
        if (cur.write) check("setup_pwdata", {32'd0, pwdata}, {32'd0, cur.wdata});
        acc = 0;
        in_xfer = 1'b1;
      end
    end else if (psel && penable) begin
      acc++;
      check("access_paddr", {32'd0, paddr}, {32'd0, cur.addr});
      if (acc == cur.waits + 1) begin
        pready = 1'b1; prdata = cur.rdata; pslverr = cur.slverr;
      end else begin
        // Error and data lines are junk while not ready; the bridge must ignore them.
        pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      if (in_xfer) begin
        check("access_cycles", 64'(acc), 64'((cur.waits >= TMO) ? TMO : cur.waits + 1));
        in_xfer = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each accepted response.
  always @(negedge clk) begin
    rsp_t e;
    if (rstn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp", {30'd0, rsp_rdata, rsp_err, rsp_timeout}, {30'd0, e.rdata, e.err, e.tmo});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_ctrl", {59'd0, psel, penable, rsp_valid, busy, rsp_err}, 64'd0);
    check("rst_paddr", {32'd0, paddr}, 64'd0);
    @(negedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;

    latency_write();

    // Read with 3 wait states; junk pslverr during waits must be ignored.
    push(1'b0, 32'h0000_0010, '0, 3, 32'h1234_5678, 1'b0);
    wait_idle();
    // Read with slave error at completion; data still captured.
    push(1'b0, 32'h0000_0020, '0, 1, 32'hCAFE_F00D, 1'b1);
    // Write with slave error: err set, data zero.
    push(1'b1, 32'h0000_0024, 32'h0BAD_0BAD, 0, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    // Timeout, then completion on the final allowed cycle.
    push(1'b0, 32'h0000_0030, '0, 99, 32'h1111_1111, 1'b0);
    wait_idle();
    push(1'b0, 32'h0000_0034, '0, TMO - 1, 32'h2222_3333, 1'b0);
    wait_idle();

    // Back-pressure: one in flight plus DEPTH buffered.
    rsp_ready = 1'b0;
    push(1'b1, 32'h0000_0100, 32'h0000_00A1, 0, '0, 1'b0);
    push(1'b0, 32'h0000_0104, '0, 2, 32'h0000_00B2, 1'b0);
    push(1'b1, 32'h0000_0108, 32'h0000_00C3, 1, '0, 1'b0);
    push(1'b0, 32'h0000_010C, '0, 0, 32'h0000_00D4, 1'b0);
    push(1'b0, 32'h0000_0110, '0, 0, 32'h0000_00E5, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("full_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("full_busy_rspv", {62'd0, busy, rsp_valid}, 64'd3);
    check("full_queued", 64'(exp_q.size()), 64'd5);
    rsp_ready = 1'b1;
    wait_idle();
    check("full_drained", 64'(exp_q.size()), 64'd0);

    // Reset during ACCESS with commands queued.
    push(1'b0, 32'h0000_0040, '0, 99, 32'h4444_4444, 1'b0);
    push(1'b0, 32'h0000_0044, '0, 0, 32'h5555_5555, 1'b0);
    push(1'b1, 32'h0000_0048, 32'h6666_6666, 0, '0, 1'b0);
    budget = 0;
    while (!(psel && penable) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("pre_rst_access", {62'd0, psel, penable}, 64'd3);
    @(negedge clk); #2 rstn = 1'b0;
    #1;
    check("mid_rst_ctrl", {60'd0, psel, penable, rsp_valid, busy}, 64'd0);
    check("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    cfg_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    latency_write();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
